// File: rtl/slave_rx_pkg.sv
// ---------------------------------------------------------------------------
// slave_rx_pkg
//   Shared definitions for the serial slave receiver: receive-FSM state
//   encoding, default field widths and the odd-parity check used by every
//   serial field.
// ---------------------------------------------------------------------------
package slave_rx_pkg;

   localparam int unsigned SRX_ADDR_WIDTH = 12;
   localparam int unsigned SRX_DATA_WIDTH = 8;
   localparam int unsigned SRX_BURST_W    = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FIRST = 2'd1,
      ST_BURST = 2'd2
   } srx_state_e;

   // A field plus its parity bit is good when the total count of ones is odd.
   // Callers zero-extend, which leaves the XOR reduction unchanged.
   function automatic logic odd_parity_ok(input logic [63:0] i_bits);
      return ^i_bits;
   endfunction

endpackage

// File: rtl/serial_shift_par.sv
// ---------------------------------------------------------------------------
// serial_shift_par
//   LSB-first shift register for one serial field of WIDTH bits followed by
//   one odd-parity bit.
//   Ports:
//     clk, reset  : clock, synchronous active-high reset (clears the register)
//     i_en        : shift i_bit in this cycle
//     i_bit       : serial input bit
//     o_word      : received field, including the bit shifted this cycle
//     o_par_ok    : field plus parity has odd weight
// ---------------------------------------------------------------------------
module serial_shift_par
   import slave_rx_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   input  logic             i_bit,
   output logic [WIDTH-1:0] o_word,
   output logic             o_par_ok
);

   logic [WIDTH:0] r_shift;
   logic [WIDTH:0] w_shift_nxt;
   logic [WIDTH:0] w_view;

   // New bits enter at the top; after WIDTH+1 shifts the first bit sits at
   // bit 0 and the parity bit at bit WIDTH.
   assign w_shift_nxt = {i_bit, r_shift[WIDTH:1]};

   // While shifting, the word ends on the bit arriving now, so look through
   // to the next value; once shifting stops the register already holds it.
   assign w_view   = i_en ? w_shift_nxt : r_shift;
   assign o_word   = w_view[WIDTH-1:0];
   assign o_par_ok = odd_parity_ok(64'(w_view));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_shift <= '0;
      end else if (i_en) begin
         r_shift <= w_shift_nxt;
      end
   end

endmodule

// File: rtl/slave_serial_rx.sv
// ---------------------------------------------------------------------------
// slave_serial_rx
//   Serial slave receiver. A frame carries an address and first data word in
//   parallel on rx_address / rx_data (LSB first, each followed by an odd
//   parity bit), then for write bursts further data words on rx_data only.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     master_valid        : frame qualifier, high for the whole frame
//     rx_address, rx_data : serial address / data bits
//     read_en, write_en   : request type, sampled on the start cycle
//     burst_len           : write words minus one, sampled on the start cycle
//     mem_busy            : downstream busy, blocks new frames
//     slave_ready         : idle and able to accept a frame
//     rx_done / rx_error  : one-cycle pulse per good word / bad word or abort
//     address, data       : received word, updated only with rx_done
//     is_write            : frame type of the last good word
// ---------------------------------------------------------------------------
module slave_serial_rx
   import slave_rx_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = SRX_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = SRX_DATA_WIDTH,
   parameter int unsigned BURST_W    = SRX_BURST_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  master_valid,
   input  logic                  rx_address,
   input  logic                  rx_data,
   input  logic                  read_en,
   input  logic                  write_en,
   input  logic [BURST_W-1:0]    burst_len,
   input  logic                  mem_busy,
   output logic                  slave_ready,
   output logic                  rx_done,
   output logic                  rx_error,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  is_write
);

   localparam int unsigned L0    = ((ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH) + 1;
   localparam int unsigned CNT_W = $clog2(L0 + 1);

   srx_state_e            r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [BURST_W-1:0]    r_words;
   logic [ADDR_WIDTH-1:0] r_next_addr;
   logic                  r_wr_frame;
   logic                  r_ready_ok;

   logic                  w_start;
   logic                  w_addr_en;
   logic                  w_data_en;
   logic [ADDR_WIDTH-1:0] w_addr_word;
   logic [DATA_WIDTH-1:0] w_data_word;
   logic                  w_addr_ok;
   logic                  w_data_ok;
   logic                  w_first_last;
   logic                  w_burst_last;
   logic                  w_first_ok;
   logic                  w_unused_read_en;

   // A frame is a read whenever write_en is low, so read_en adds nothing.
   assign w_unused_read_en = read_en;

   // r_ready_ok is low only in the cycle right after reset and while a frame
   // is in progress; mem_busy gates it combinationally.
   assign slave_ready = r_ready_ok & ~mem_busy;
   assign w_start     = (r_state == ST_IDLE) & master_valid & slave_ready;

   // Bit 0 of both lines arrives on the start cycle (still IDLE).
   assign w_addr_en = w_start | ((r_state == ST_FIRST) && (r_cnt <= CNT_W'(ADDR_WIDTH)));
   assign w_data_en = w_start | ((r_state == ST_FIRST) && (r_cnt <= CNT_W'(DATA_WIDTH)))
                    | (r_state == ST_BURST);

   assign w_first_last = (r_state == ST_FIRST) && (r_cnt == CNT_W'(L0 - 1));
   assign w_burst_last = (r_state == ST_BURST) && (r_cnt == CNT_W'(DATA_WIDTH));
   assign w_first_ok   = w_addr_ok & (~r_wr_frame | w_data_ok);

   serial_shift_par #(.WIDTH(ADDR_WIDTH)) u_addr_sh (
      .clk      (clk),
      .reset    (reset),
      .i_en     (w_addr_en),
      .i_bit    (rx_address),
      .o_word   (w_addr_word),
      .o_par_ok (w_addr_ok)
   );

   serial_shift_par #(.WIDTH(DATA_WIDTH)) u_data_sh (
      .clk      (clk),
      .reset    (reset),
      .i_en     (w_data_en),
      .i_bit    (rx_data),
      .o_word   (w_data_word),
      .o_par_ok (w_data_ok)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_words     <= '0;
         r_next_addr <= '0;
         r_wr_frame  <= 1'b0;
         r_ready_ok  <= 1'b0;
         rx_done     <= 1'b0;
         rx_error    <= 1'b0;
         address     <= '0;
         data        <= '0;
         is_write    <= 1'b0;
      end else begin
         rx_done  <= 1'b0;
         rx_error <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_state    <= ST_FIRST;
                  r_cnt      <= CNT_W'(1);
                  r_wr_frame <= write_en;
                  r_words    <= write_en ? burst_len : '0;
                  r_ready_ok <= 1'b0;
               end else begin
                  r_ready_ok <= 1'b1;
               end
            end
            ST_FIRST: begin
               if (!master_valid) begin
                  rx_error   <= 1'b1;
                  r_state    <= ST_IDLE;
                  r_cnt      <= '0;
                  r_words    <= '0;
                  r_ready_ok <= 1'b1;
               end else if (w_first_last) begin
                  if (w_first_ok) begin
                     rx_done  <= 1'b1;
                     address  <= w_addr_word;
                     is_write <= r_wr_frame;
                     if (r_wr_frame) begin
                        data <= w_data_word;
                     end
                  end else begin
                     rx_error <= 1'b1;
                  end
                  // Burst addresses follow the received base even if this
                  // word failed parity.
                  r_next_addr <= w_addr_word + ADDR_WIDTH'(1);
                  r_cnt       <= '0;
                  if (r_words != '0) begin
                     r_state <= ST_BURST;
                  end else begin
                     r_state    <= ST_IDLE;
                     r_ready_ok <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_BURST: begin
               if (!master_valid) begin
                  rx_error   <= 1'b1;
                  r_state    <= ST_IDLE;
                  r_cnt      <= '0;
                  r_words    <= '0;
                  r_ready_ok <= 1'b1;
               end else if (w_burst_last) begin
                  if (w_data_ok) begin
                     rx_done  <= 1'b1;
                     address  <= r_next_addr;
                     data     <= w_data_word;
                     is_write <= 1'b1;
                  end else begin
                     rx_error <= 1'b1;
                  end
                  r_next_addr <= r_next_addr + ADDR_WIDTH'(1);
                  r_words     <= r_words - BURST_W'(1);
                  r_cnt       <= '0;
                  if (r_words == BURST_W'(1)) begin
                     r_state    <= ST_IDLE;
                     r_ready_ok <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_slave_serial_rx.sv
// ---------------------------------------------------------------------------
// tb_slave_serial_rx
//   Directed and randomized frames against a frame-level reference model:
//   expected pulse cycles, addresses and data are derived from the frame
//   description (word k ends at L0 + k*(DATA+1), address base+k mod 2^A).
// ---------------------------------------------------------------------------
module tb_slave_serial_rx;

   localparam int A  = 12;
   localparam int D  = 8;
   localparam int BW = 3;
   localparam int L0 = ((A > D) ? A : D) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          master_valid;
   logic          rx_address;
   logic          rx_data;
   logic          read_en;
   logic          write_en;
   logic [BW-1:0] burst_len;
   logic          mem_busy;
   logic          slave_ready;
   logic          rx_done;
   logic          rx_error;
   logic [A-1:0]  address;
   logic [D-1:0]  data;
   logic          is_write;

   int errors = 0;
   int checks = 0;
   int fno    = 0;

   // Model of the held outputs
   logic [A-1:0] exp_addr;
   logic [D-1:0] exp_data;
   logic         exp_wr;

   // Current frame description
   logic         f_wr;
   logic         f_rd;
   logic [A-1:0] f_addr;
   int           f_blen;
   logic [D-1:0] f_data   [0:7];
   logic         f_bad_ap;
   logic         f_bad_dp [0:7];
   int           f_abort;
   int           f_rst;

   always #5 clk = ~clk;

   slave_serial_rx #(
      .ADDR_WIDTH (A),
      .DATA_WIDTH (D),
      .BURST_W    (BW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .master_valid (master_valid),
      .rx_address   (rx_address),
      .rx_data      (rx_data),
      .read_en      (read_en),
      .write_en     (write_en),
      .burst_len    (burst_len),
      .mem_busy     (mem_busy),
      .slave_ready  (slave_ready),
      .rx_done      (rx_done),
      .rx_error     (rx_error),
      .address      (address),
      .data         (data),
      .is_write     (is_write)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_outputs(input string tag, input logic e_done, input logic e_err,
                                input logic e_rdy);
      chk({tag, " rx_done"},     32'(rx_done),     32'(e_done));
      chk({tag, " rx_error"},    32'(rx_error),    32'(e_err));
      chk({tag, " slave_ready"}, 32'(slave_ready), 32'(e_rdy));
      chk({tag, " address"},     32'(address),     32'(exp_addr));
      chk({tag, " data"},        32'(data),        32'(exp_data));
      chk({tag, " is_write"},    32'(is_write),    32'(exp_wr));
   endtask

   function automatic int frame_len();
      return f_wr ? L0 + f_blen * (D + 1) : L0;
   endfunction

   function automatic logic odd_bit(input logic [31:0] v);
      return ($countones(v) % 2) == 0;
   endfunction

   task automatic new_frame(input logic wr, input logic rd, input logic [A-1:0] addr,
                            input int blen);
      f_wr     = wr;
      f_rd     = rd;
      f_addr   = addr;
      f_blen   = blen;
      f_bad_ap = 1'b0;
      f_abort  = 0;
      f_rst    = 0;
      for (int k = 0; k < 8; k++) begin
         f_data[k]   = D'($urandom);
         f_bad_dp[k] = 1'b0;
      end
   endtask

   task automatic run_frame();
      int   t_len;
      int   nwords;
      int   endc;
      int   k;
      int   off;
      logic ok;
      logic e_done;
      logic e_err;
      logic e_rdy;
      string tag;
      t_len  = frame_len();
      nwords = f_wr ? f_blen + 1 : 1;
      endc   = t_len;
      if (f_abort > 0) endc = f_abort + 1;
      if (f_rst > 0)   endc = f_rst + 1;
      fno++;
      for (int c = 0; c <= endc; c++) begin
         @(posedge clk); #1;
         mem_busy     = 1'b0;
         reset        = (f_rst > 0) && (c == f_rst);
         master_valid = (c < t_len) && !(f_abort > 0 && c >= f_abort)
                        && !(f_rst > 0 && c > f_rst);
         write_en     = (c == 0) ? f_wr : 1'($urandom);
         read_en      = (c == 0) ? f_rd : 1'($urandom);
         burst_len    = (c == 0) ? BW'(f_blen) : BW'($urandom);
         if (c < A)       rx_address = f_addr[c];
         else if (c == A) rx_address = odd_bit(32'(f_addr)) ^ f_bad_ap;
         else             rx_address = 1'($urandom);
         if (c < L0) begin
            k   = 0;
            off = c;
         end else begin
            k   = 1 + (c - L0) / (D + 1);
            off = (c - L0) % (D + 1);
         end
         if (!f_wr || k > f_blen || off > D) rx_data = 1'($urandom);
         else if (off < D)                   rx_data = f_data[k][off];
         else                                rx_data = odd_bit(32'(f_data[k])) ^ f_bad_dp[k];

         @(negedge clk);
         e_done = 1'b0;
         e_err  = 1'b0;
         e_rdy  = (c == 0) || (c == endc);
         if (f_rst > 0 && c == endc) begin
            exp_addr = '0;
            exp_data = '0;
            exp_wr   = 1'b0;
            e_rdy    = 1'b0;
         end else if (f_abort > 0 && c == endc) begin
            e_err = 1'b1;
         end else if (c >= L0 && (c - L0) % (D + 1) == 0 && (c - L0) / (D + 1) < nwords) begin
            k  = (c - L0) / (D + 1);
            ok = (k == 0) ? (!f_bad_ap && (!f_wr || !f_bad_dp[0])) : !f_bad_dp[k];
            if (ok) begin
               e_done   = 1'b1;
               exp_addr = A'(f_addr + k);
               if (f_wr) exp_data = f_data[k];
               exp_wr   = f_wr;
            end else begin
               e_err = 1'b1;
            end
         end
         tag = $sformatf("frame%0d c%0d", fno, c);
         check_outputs(tag, e_done, e_err, e_rdy);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         reset        = 1'b0;
         mem_busy     = 1'b0;
         master_valid = 1'b0;
         rx_address   = 1'($urandom);
         rx_data      = 1'($urandom);
         write_en     = 1'($urandom);
         read_en      = 1'($urandom);
         burst_len    = BW'($urandom);
         @(negedge clk);
         check_outputs("idle", 1'b0, 1'b0, 1'b1);
      end
   endtask

   task automatic busy(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         mem_busy     = 1'b1;
         master_valid = 1'b1;
         write_en     = 1'b1;
         rx_address   = 1'($urandom);
         rx_data      = 1'($urandom);
         burst_len    = BW'($urandom);
         @(negedge clk);
         check_outputs("busy", 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      reset        = 1'b1;
      master_valid = 1'b0;
      rx_address   = 1'b0;
      rx_data      = 1'b0;
      read_en      = 1'b0;
      write_en     = 1'b0;
      burst_len    = '0;
      mem_busy     = 1'b0;
      exp_addr     = '0;
      exp_data     = '0;
      exp_wr       = 1'b0;

      repeat (2) begin
         @(posedge clk); #1;
         @(negedge clk);
         check_outputs("reset", 1'b0, 1'b0, 1'b0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_outputs("reset_release", 1'b0, 1'b0, 1'b0);
      idle(2);

      // Single write
      new_frame(1'b1, 1'b0, 12'hA35, 0);
      f_data[0] = 8'h5C;
      run_frame();
      idle(2);

      // Read of the top address, burst_len ignored, data held
      new_frame(1'b0, 1'b1, 12'hFFF, 5);
      run_frame();
      idle(1);

      // Burst wrapping the address space
      new_frame(1'b1, 1'b0, 12'hFFE, 2);
      f_data[0] = 8'h11;
      f_data[1] = 8'h22;
      f_data[2] = 8'h33;
      run_frame();
      idle(1);

      // Address parity error
      new_frame(1'b1, 1'b0, 12'h123, 0);
      f_bad_ap = 1'b1;
      run_frame();
      idle(1);

      // Burst with a bad middle word
      new_frame(1'b1, 1'b0, 12'h400, 2);
      f_bad_dp[1] = 1'b1;
      run_frame();
      idle(1);

      // Abort at cycle 5
      new_frame(1'b1, 1'b0, 12'h0F0, 0);
      f_abort = 5;
      run_frame();
      idle(1);

      // Back-to-back frame straight after a completed one
      new_frame(1'b1, 1'b1, 12'h3C3, 1);
      run_frame();
      new_frame(1'b0, 1'b0, 12'h001, 0);
      run_frame();

      // Reset at cycle 7 of a burst
      new_frame(1'b1, 1'b0, 12'h777, 1);
      f_rst = 7;
      run_frame();
      idle(2);

      // mem_busy blocks a pending frame, release starts it at once
      busy(4);
      new_frame(1'b1, 1'b0, 12'h055, 0);
      run_frame();
      idle(1);

      // Randomized frames
      for (int n = 0; n < 12; n++) begin
         new_frame(1'($urandom), 1'($urandom), A'($urandom), int'($urandom_range(7, 0)));
         f_bad_ap = ($urandom % 6) == 0;
         for (int k = 0; k < 8; k++) f_bad_dp[k] = ($urandom % 6) == 0;
         if ($urandom % 4 == 0) f_abort = int'($urandom_range(frame_len() - 1, 1));
         run_frame();
         idle(int'($urandom_range(2, 0)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
